// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver FSM state encoding and bit-period arithmetic,
// so the transmitter and receiver agree on the same clocks-per-bit value.
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_STOP,
        ST_BREAK
    } uart_state_e;

    function automatic int unsigned calc_c_bit(input int unsigned clk_frq, input int unsigned baud);
        return clk_frq / baud;
    endfunction

    function automatic int unsigned calc_c_half(input int unsigned clk_frq, input int unsigned baud);
        return calc_c_bit(clk_frq, baud) / 2;
    endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer for the serial line. With UART_RX_MAJORITY_EN defined it also keeps
// a short history of the synchronized line and presents the 2-of-3 vote as the sample.
module uart_rx_sync (
    input  logic CLK,
    input  logic RESET,
    input  logic rx_i,
    output logic rx_s_o,
    output logic smp_o
);
    logic meta_q;
    logic rx_s_q;

    // NOTE: both flops reset to 1 (idle line) so leaving reset never looks like a start bit.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            meta_q <= 1'b1;
            rx_s_q <= 1'b1;
        end else begin
            meta_q <= rx_i;
            rx_s_q <= meta_q;
        end
    end

    assign rx_s_o = rx_s_q;

`ifdef UART_RX_MAJORITY_EN
    // Taps are rx_s now, one and two clocks ago: the window T-1..T+1 seen at T+1.
    logic [1:0] hist_q;

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            hist_q <= 2'b11;
        end else begin
            hist_q <= {hist_q[0], rx_s_q};
        end
    end

    assign smp_o = (rx_s_q & hist_q[0]) | (rx_s_q & hist_q[1]) | (hist_q[0] & hist_q[1]);
`else
    assign smp_o = rx_s_q;
`endif

endmodule

// File: rtl/uart_receive.sv
// 8N1 UART receiver with mid-bit sampling, framing-error and line-break handling.
// Optional macro UART_RX_MAJORITY_EN selects 2-of-3 majority sampling.
module uart_receive
    import uart_pkg::*;
#(
    parameter int unsigned P_CLK_FRQ = 48_000_000,
    parameter int unsigned P_BAURATE = 9600
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic       UART_RX,
    output logic [7:0] DATA,
    output logic       DATA_VLD,
    output logic       FRAME_ERR,
    output logic       BUSY
);
    localparam int unsigned C_BIT  = calc_c_bit(P_CLK_FRQ, P_BAURATE);
    localparam int unsigned C_HALF = calc_c_half(P_CLK_FRQ, P_BAURATE);

    if (C_BIT < 4 || C_BIT > 65535) begin : g_bad_c_bit
        $error("uart_receive: clocks per bit must be within 4..65535");
    end

`ifdef UART_RX_MAJORITY_EN
    localparam int unsigned C_DLY = 1;
`else
    localparam int unsigned C_DLY = 0;
`endif

    // Voting decides one clock late; reloading the counter with C_DLY keeps the bit cadence.
    localparam logic [15:0] C_START_AT = 16'(C_HALF - 1 + C_DLY);
    localparam logic [15:0] C_BIT_AT   = 16'(C_BIT - 1 + C_DLY);
    localparam logic [15:0] C_RELOAD   = 16'(C_DLY);

    logic rx_s;
    logic rx_smp;

    uart_rx_sync u_sync (
        .CLK    (CLK),
        .RESET  (RESET),
        .rx_i   (UART_RX),
        .rx_s_o (rx_s),
        .smp_o  (rx_smp)
    );

    uart_state_e state_q;
    logic [15:0] cnt_q;
    logic [2:0]  idx_q;
    logic [7:0]  shift_q;
    logic [7:0]  data_q;
    logic        vld_q;
    logic        err_q;

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            shift_q <= '0;
            data_q  <= '0;
            vld_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            vld_q <= 1'b0;
            err_q <= 1'b0;
            cnt_q <= cnt_q + 16'd1;
            case (state_q)
                ST_IDLE: begin
                    cnt_q <= '0;
                    if (!rx_s) state_q <= ST_START;
                end
                ST_START: begin
                    if (cnt_q == C_START_AT) begin
                        cnt_q   <= C_RELOAD;
                        idx_q   <= '0;
                        state_q <= rx_smp ? ST_IDLE : ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (cnt_q == C_BIT_AT) begin
                        cnt_q          <= C_RELOAD;
                        shift_q[idx_q] <= rx_smp;
                        idx_q          <= idx_q + 3'd1;
                        if (idx_q == 3'd7) state_q <= ST_STOP;
                    end
                end
                ST_STOP: begin
                    if (cnt_q == C_BIT_AT) begin
                        cnt_q <= C_RELOAD;
                        if (rx_smp) begin
                            data_q  <= shift_q;
                            vld_q   <= 1'b1;
                            state_q <= ST_IDLE;
                        end else begin
                            err_q   <= 1'b1;
                            state_q <= ST_BREAK;
                        end
                    end
                end
                ST_BREAK: begin
                    // A held-low line must go idle before the next start bit can be trusted.
                    cnt_q <= '0;
                    if (rx_s) state_q <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign DATA      = data_q;
    assign DATA_VLD  = vld_q;
    assign FRAME_ERR = err_q;
    assign BUSY      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_uart_receive.sv
// Scoreboard bench for uart_receive: a behavioural 8N1 driver queues the expected outcome of
// each frame and a negedge monitor checks every DATA_VLD / FRAME_ERR strobe against it.
`timescale 1ns/1ps
module tb_uart_receive;

    localparam int P_BAURATE = 9600;
    localparam int C_BIT     = 24;
    localparam int P_CLK_FRQ = C_BIT * P_BAURATE;
    localparam int C_HALF    = C_BIT / 2;
`ifdef UART_RX_MAJORITY_EN
    localparam int VOTE_DLY = 1;
`else
    localparam int VOTE_DLY = 0;
`endif
    // Strobe lands half a bit plus nine bits after the start edge, plus the 2-clock synchronizer.
    localparam int STROBE_LAT = C_HALF + 9 * C_BIT + 2 + VOTE_DLY;

    logic       CLK = 1'b0;
    logic       RESET = 1'b0;
    logic       UART_RX = 1'b1;
    logic [7:0] DATA;
    logic       DATA_VLD;
    logic       FRAME_ERR;
    logic       BUSY;

    uart_receive #(
        .P_CLK_FRQ (P_CLK_FRQ),
        .P_BAURATE (P_BAURATE)
    ) dut (
        .CLK       (CLK),
        .RESET     (RESET),
        .UART_RX   (UART_RX),
        .DATA      (DATA),
        .DATA_VLD  (DATA_VLD),
        .FRAME_ERR (FRAME_ERR),
        .BUSY      (BUSY)
    );

    always #5 CLK = ~CLK;

    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    typedef struct {
        logic       is_err;
        logic [7:0] data;
        int         t_fall;
    } exp_t;

    exp_t       exp_q[$];
    exp_t       mon_e;
    logic [7:0] good_data = 8'h00;
    logic       prev_strobe = 1'b0;
    int         tests = 0;
    int         fails = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_near(input string name, input int act, input int exp, input int tol);
        tests++;
        if (act < exp - tol || act > exp + tol) begin
            fails++;
            $display("FAIL %s: got %0d, want %0d +/- %0d (t=%0t)", name, act, exp, tol, $time);
        end
    endtask

    // Monitor: every strobe must match the oldest queued frame; DATA may only move on DATA_VLD.
    always @(negedge CLK) begin
        if (!RESET) begin
            prev_strobe = 1'b0;
        end else begin
            if (DATA_VLD || FRAME_ERR) begin
                check("strobe_exclusive", {31'd0, DATA_VLD & FRAME_ERR}, 32'd0);
                check("strobe_one_cycle", {31'd0, prev_strobe}, 32'd0);
                check("strobe_expected", {31'd0, exp_q.size() > 0}, 32'd1);
                if (exp_q.size() > 0) begin
                    mon_e = exp_q.pop_front();
                    check("strobe_kind_err", {31'd0, FRAME_ERR}, {31'd0, mon_e.is_err});
                    if (!mon_e.is_err) good_data = mon_e.data;
                    check("strobe_data", {24'd0, DATA}, {24'd0, good_data});
                    check_near("strobe_latency", cyc - mon_e.t_fall, STROBE_LAT, 1);
                end
            end else if (DATA !== good_data) begin
                check("data_held", {24'd0, DATA}, {24'd0, good_data});
            end
            prev_strobe = DATA_VLD | FRAME_ERR;
        end
    end

    // One 8N1 frame, one line value per clock; optional single-clock inversion and early abort.
    task automatic send_frame(input logic [7:0] b, input logic stop, input int glitch_at,
                              input int abort_at, input logic [7:0] exp_b);
        logic [9:0] bits;
        bits = {stop, b, 1'b0};
        for (int i = 0; i < 10 * C_BIT; i++) begin
            @(negedge CLK);
            if (i == abort_at) return;
            if (i == 0) exp_q.push_back('{is_err: !stop, data: exp_b, t_fall: cyc});
            UART_RX = bits[i / C_BIT] ^ (i == glitch_at);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge CLK);
            UART_RX = 1'b1;
        end
    endtask

    task automatic wait_busy_low(input int t0, input int bound, output int lat, output logic seen_hi);
        lat = -1;
        seen_hi = 1'b0;
        for (int k = 0; k < bound; k++) begin
            @(negedge CLK);
            if (BUSY) seen_hi = 1'b1;
            else if (seen_hi || k > 0) begin
                lat = cyc - t0;
                break;
            end
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_data"}, {24'd0, DATA}, 32'd0);
        check({tag, "_vld"}, {31'd0, DATA_VLD}, 32'd0);
        check({tag, "_err"}, {31'd0, FRAME_ERR}, 32'd0);
        check({tag, "_busy"}, {31'd0, BUSY}, 32'd0);
    endtask

    int   t0;
    int   lat;
    logic seen_hi;
    logic busy_ok;

    initial begin
        repeat (3) @(negedge CLK);
        #1 check_reset_outputs("reset");
        @(negedge CLK);
        RESET = 1'b1;
        idle(4);

        // Clean frame
        send_frame(8'hA5, 1'b1, -1, -1, 8'hA5);
        idle(C_BIT);

        // Short low pulse on an idle line: rejected start bit
        @(negedge CLK);
        UART_RX = 1'b0;
        t0 = cyc;
        repeat (4) @(negedge CLK);
        UART_RX = 1'b1;
        wait_busy_low(t0, 4 * C_BIT, lat, seen_hi);
        check("glitch_busy_seen", {31'd0, seen_hi}, 32'd1);
        check_near("glitch_busy_fall", lat, C_HALF + 2, 3);
        idle(C_BIT);

        // Good frame, then a bad stop bit with the line held low
        send_frame(8'hA5, 1'b1, -1, -1, 8'hA5);
        send_frame(8'h3C, 1'b0, -1, -1, 8'h3C);
        busy_ok = 1'b1;
        for (int k = 0; k < 4 * C_BIT; k++) begin
            @(negedge CLK);
            UART_RX = 1'b0;
            busy_ok &= BUSY;
        end
        check("break_busy_held", {31'd0, busy_ok}, 32'd1);
        @(negedge CLK);
        UART_RX = 1'b1;
        t0 = cyc;
        wait_busy_low(t0, 10, lat, seen_hi);
        check_near("break_busy_fall", lat, 2, 1);
        check("break_err_seen", exp_q.size(), 32'd0);
        idle(C_BIT);

        // Back-to-back frames with zero idle
        send_frame(8'h00, 1'b1, -1, -1, 8'h00);
        send_frame(8'hFF, 1'b1, -1, -1, 8'hFF);
        idle(C_BIT);
        check("b2b_both_seen", exp_q.size(), 32'd0);

        // Reset asserted during data bit 4
        send_frame(8'hC3, 1'b1, -1, 5 * C_BIT + C_HALF / 2, 8'hC3);
        #2 RESET = 1'b0;
        UART_RX = 1'b1;
        exp_q.delete();
        good_data = 8'h00;
        #1 check_reset_outputs("midrst");
        repeat (3) @(negedge CLK);
        #1 check_reset_outputs("midrst_hold");
        @(negedge CLK);
        RESET = 1'b1;
        idle(3);
        send_frame(8'h5A, 1'b1, -1, -1, 8'h5A);
        idle(C_BIT);

        // One-clock inversion at the bit-2 sample point of 0x0F
`ifdef UART_RX_MAJORITY_EN
        send_frame(8'h0F, 1'b1, C_HALF + 3 * C_BIT, -1, 8'h0F);
`else
        send_frame(8'h0F, 1'b1, C_HALF + 3 * C_BIT, -1, 8'h0B);
`endif
        idle(C_BIT);

        // Randomized traffic, occasional bad stop bits, random gaps
        for (int n = 0; n < 24; n++) begin
            logic [7:0] b;
            logic       bad;
            b   = 8'($urandom);
            bad = ($urandom_range(0, 7) == 0);
            send_frame(b, !bad, -1, -1, b);
            if (bad) idle($urandom_range(4, C_BIT));
            else if ($urandom_range(0, 1) == 1) idle($urandom_range(1, C_BIT));
        end
        idle(2 * C_BIT);
        check("queue_drained", exp_q.size(), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #3_000_000;
        fails++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
